// File: rtl/om_pkg.sv
// Shared types, DCR encodings and per-channel blend helpers for the OM blend engine.
// OM_BLEND_LOGICOP_EN enables the raw-bit logic-op combine mode.
package om_pkg;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } om_color_t;

  typedef struct packed {
    logic [3:0] blend_src_rgb;
    logic [3:0] blend_src_a;
    logic [3:0] blend_dst_rgb;
    logic [3:0] blend_dst_a;
    logic [2:0] blend_mode_rgb;
    logic [2:0] blend_mode_a;
    om_color_t  blend_const;
    logic [3:0] logic_op;
  } om_dcrs_t;

  localparam logic [3:0] OM_BLEND_FUNC_ZERO                = 4'd0;
  localparam logic [3:0] OM_BLEND_FUNC_ONE                 = 4'd1;
  localparam logic [3:0] OM_BLEND_FUNC_SRC_RGB             = 4'd2;
  localparam logic [3:0] OM_BLEND_FUNC_ONE_MINUS_SRC_RGB   = 4'd3;
  localparam logic [3:0] OM_BLEND_FUNC_DST_RGB             = 4'd4;
  localparam logic [3:0] OM_BLEND_FUNC_ONE_MINUS_DST_RGB   = 4'd5;
  localparam logic [3:0] OM_BLEND_FUNC_SRC_A               = 4'd6;
  localparam logic [3:0] OM_BLEND_FUNC_ONE_MINUS_SRC_A     = 4'd7;
  localparam logic [3:0] OM_BLEND_FUNC_DST_A               = 4'd8;
  localparam logic [3:0] OM_BLEND_FUNC_ONE_MINUS_DST_A     = 4'd9;
  localparam logic [3:0] OM_BLEND_FUNC_CONST_RGB           = 4'd10;
  localparam logic [3:0] OM_BLEND_FUNC_ONE_MINUS_CONST_RGB = 4'd11;
  localparam logic [3:0] OM_BLEND_FUNC_CONST_A             = 4'd12;
  localparam logic [3:0] OM_BLEND_FUNC_ONE_MINUS_CONST_A   = 4'd13;
  localparam logic [3:0] OM_BLEND_FUNC_ALPHA_SAT           = 4'd14;

  localparam logic [2:0] OM_BLEND_MODE_ADD     = 3'd0;
  localparam logic [2:0] OM_BLEND_MODE_SUB     = 3'd1;
  localparam logic [2:0] OM_BLEND_MODE_REV_SUB = 3'd2;
  localparam logic [2:0] OM_BLEND_MODE_MIN     = 3'd3;
  localparam logic [2:0] OM_BLEND_MODE_MAX     = 3'd4;
  localparam logic [2:0] OM_BLEND_MODE_LOGICOP = 3'd5;

  localparam logic [3:0] OM_LOGIC_OP_CLEAR         = 4'd0;
  localparam logic [3:0] OM_LOGIC_OP_AND           = 4'd1;
  localparam logic [3:0] OM_LOGIC_OP_AND_REVERSE   = 4'd2;
  localparam logic [3:0] OM_LOGIC_OP_COPY          = 4'd3;
  localparam logic [3:0] OM_LOGIC_OP_AND_INVERTED  = 4'd4;
  localparam logic [3:0] OM_LOGIC_OP_NOOP          = 4'd5;
  localparam logic [3:0] OM_LOGIC_OP_XOR           = 4'd6;
  localparam logic [3:0] OM_LOGIC_OP_OR            = 4'd7;
  localparam logic [3:0] OM_LOGIC_OP_NOR           = 4'd8;
  localparam logic [3:0] OM_LOGIC_OP_EQUIV         = 4'd9;
  localparam logic [3:0] OM_LOGIC_OP_INVERT        = 4'd10;
  localparam logic [3:0] OM_LOGIC_OP_OR_REVERSE    = 4'd11;
  localparam logic [3:0] OM_LOGIC_OP_COPY_INVERTED = 4'd12;
  localparam logic [3:0] OM_LOGIC_OP_OR_INVERTED   = 4'd13;
  localparam logic [3:0] OM_LOGIC_OP_NAND          = 4'd14;
  localparam logic [3:0] OM_LOGIC_OP_SET           = 4'd15;

  // Channel index ch: 3 = alpha, 2 = red, 1 = green, 0 = blue.
  function automatic logic [7:0] om_blend_factor(input logic [3:0] func, input om_color_t src,
                                                 input om_color_t dst, input om_color_t cst,
                                                 input logic [1:0] ch);
    logic [3:0][7:0] s, d, c;
    logic [7:0] f;
    s = src;
    d = dst;
    c = cst;
    case (func)
      OM_BLEND_FUNC_ONE:                 f = '1;
      OM_BLEND_FUNC_SRC_RGB:             f = s[ch];
      OM_BLEND_FUNC_ONE_MINUS_SRC_RGB:   f = ~s[ch];
      OM_BLEND_FUNC_DST_RGB:             f = d[ch];
      OM_BLEND_FUNC_ONE_MINUS_DST_RGB:   f = ~d[ch];
      OM_BLEND_FUNC_SRC_A:               f = src.a;
      OM_BLEND_FUNC_ONE_MINUS_SRC_A:     f = ~src.a;
      OM_BLEND_FUNC_DST_A:               f = dst.a;
      OM_BLEND_FUNC_ONE_MINUS_DST_A:     f = ~dst.a;
      OM_BLEND_FUNC_CONST_RGB:           f = c[ch];
      OM_BLEND_FUNC_ONE_MINUS_CONST_RGB: f = ~c[ch];
      OM_BLEND_FUNC_CONST_A:             f = cst.a;
      OM_BLEND_FUNC_ONE_MINUS_CONST_A:   f = ~cst.a;
      OM_BLEND_FUNC_ALPHA_SAT:
        if (ch == 2'd3) f = '1;
        else            f = (src.a < ~dst.a) ? src.a : ~dst.a;
      default:                           f = '0;
    endcase
    return f;
  endfunction

  // Exact rounded c*f/255 without a divider.
  function automatic logic [7:0] om_mul255(input logic [7:0] c, input logic [7:0] f);
    logic [15:0] p, t, r;
    p = {8'd0, c} * {8'd0, f};
    t = p + 16'd128;
    r = t + {8'd0, t[15:8]};
    return r[15:8];
  endfunction

  function automatic logic [7:0] om_combine(input logic [2:0] mode, input logic [7:0] sw,
                                            input logic [7:0] dw, input logic [7:0] s,
                                            input logic [7:0] d);
    logic [8:0] sum;
    logic [7:0] v;
    sum = {1'b0, sw} + {1'b0, dw};
    case (mode)
      OM_BLEND_MODE_SUB:     v = (sw > dw) ? sw - dw : '0;
      OM_BLEND_MODE_REV_SUB: v = (dw > sw) ? dw - sw : '0;
      OM_BLEND_MODE_MIN:     v = (s < d) ? s : d;
      OM_BLEND_MODE_MAX:     v = (s > d) ? s : d;
      default:               v = sum[8] ? 8'hff : sum[7:0];
    endcase
    return v;
  endfunction

`ifdef OM_BLEND_LOGICOP_EN
  function automatic logic [31:0] om_logic_op(input logic [3:0] op, input logic [31:0] s,
                                              input logic [31:0] d);
    logic [31:0] v;
    case (op)
      OM_LOGIC_OP_CLEAR:         v = '0;
      OM_LOGIC_OP_AND:           v = s & d;
      OM_LOGIC_OP_AND_REVERSE:   v = s & ~d;
      OM_LOGIC_OP_COPY:          v = s;
      OM_LOGIC_OP_AND_INVERTED:  v = ~s & d;
      OM_LOGIC_OP_NOOP:          v = d;
      OM_LOGIC_OP_XOR:           v = s ^ d;
      OM_LOGIC_OP_OR:            v = s | d;
      OM_LOGIC_OP_NOR:           v = ~(s | d);
      OM_LOGIC_OP_EQUIV:         v = ~(s ^ d);
      OM_LOGIC_OP_INVERT:        v = ~d;
      OM_LOGIC_OP_OR_REVERSE:    v = s | ~d;
      OM_LOGIC_OP_COPY_INVERTED: v = ~s;
      OM_LOGIC_OP_OR_INVERTED:   v = ~s | d;
      OM_LOGIC_OP_NAND:          v = ~(s & d);
      default:                   v = '1;
    endcase
    return v;
  endfunction
`endif

endpackage

// File: rtl/om_blend_lane.sv
// One pixel lane of the blend engine: factor select, multiply and combine as three
// combinational slices; registers live in om_blend_array. OM_BLEND_LOGICOP_EN adds logic ops.
module om_blend_lane
  import om_pkg::*;
(
  input  om_color_t  src,
  input  om_color_t  dst,
  input  logic [3:0] func_src_rgb,
  input  logic [3:0] func_src_a,
  input  logic [3:0] func_dst_rgb,
  input  logic [3:0] func_dst_a,
  input  om_color_t  blend_const,
  output om_color_t  src_f,
  output om_color_t  dst_f,
  input  om_color_t  mul_src,
  input  om_color_t  mul_dst,
  input  om_color_t  mul_src_f,
  input  om_color_t  mul_dst_f,
  output om_color_t  src_w,
  output om_color_t  dst_w,
  input  om_color_t  cmb_src,
  input  om_color_t  cmb_dst,
  input  om_color_t  cmb_src_w,
  input  om_color_t  cmb_dst_w,
  input  logic [2:0] mode_rgb,
  input  logic [2:0] mode_a,
`ifdef OM_BLEND_LOGICOP_EN
  input  logic [3:0] logic_op,
`endif
  input  logic       mask,
  output om_color_t  color
);

  logic [3:0][7:0] sf, df, ms, md, msf, mdf, sw, dw, cs, cd, csw, cdw, res;
  logic [2:0]      mode;

  assign ms  = mul_src;
  assign md  = mul_dst;
  assign msf = mul_src_f;
  assign mdf = mul_dst_f;
  assign cs  = cmb_src;
  assign cd  = cmb_dst;
  assign csw = cmb_src_w;
  assign cdw = cmb_dst_w;

  always_comb begin
    sf = '0;
    df = '0;
    for (int unsigned ch = 0; ch < 4; ch++) begin
      sf[ch] = om_blend_factor((ch == 3) ? func_src_a : func_src_rgb, src, dst, blend_const, 2'(ch));
      df[ch] = om_blend_factor((ch == 3) ? func_dst_a : func_dst_rgb, src, dst, blend_const, 2'(ch));
    end
  end

  assign src_f = sf;
  assign dst_f = df;

  always_comb begin
    sw = '0;
    dw = '0;
    for (int unsigned ch = 0; ch < 4; ch++) begin
      sw[ch] = om_mul255(ms[ch], msf[ch]);
      dw[ch] = om_mul255(md[ch], mdf[ch]);
    end
  end

  assign src_w = sw;
  assign dst_w = dw;

`ifdef OM_BLEND_LOGICOP_EN
  logic [31:0] lop;
  assign lop = om_logic_op(logic_op, cmb_src, cmb_dst);
`endif

  always_comb begin
    res  = '0;
    mode = '0;
    for (int unsigned ch = 0; ch < 4; ch++) begin
      mode    = (ch == 3) ? mode_a : mode_rgb;
      res[ch] = om_combine(mode, csw[ch], cdw[ch], cs[ch], cd[ch]);
`ifdef OM_BLEND_LOGICOP_EN
      if (mode == OM_BLEND_MODE_LOGICOP) res[ch] = lop[8*ch +: 8];
`endif
    end
  end

  assign color = mask ? om_color_t'(res) : cmb_dst;

endmodule

// File: rtl/om_blend_array.sv
// Three-stage NUM_LANES-wide blend pipeline with a global valid/ready stall.
// OM_BLEND_LOGICOP_EN carries logic_op down the pipe and enables LOGICOP combine.
module om_blend_array
  import om_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned TAG_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid_in,
  output logic                            ready_in,
  input  om_dcrs_t                        dcrs,
  input  logic      [NUM_LANES-1:0]       mask_in,
  input  om_color_t [NUM_LANES-1:0]       src_color,
  input  om_color_t [NUM_LANES-1:0]       dst_color,
  input  logic      [TAG_WIDTH-1:0]       tag_in,
  output logic                            valid_out,
  input  logic                            ready_out,
  output om_color_t [NUM_LANES-1:0]       color_out,
  output logic      [NUM_LANES-1:0]       mask_out,
  output logic      [TAG_WIDTH-1:0]       tag_out
);

  logic v1, v2, v3, advance;

  logic [2:0]                 s1_mode_rgb, s1_mode_a, s2_mode_rgb, s2_mode_a;
  logic [NUM_LANES-1:0]       s1_mask, s2_mask;
  logic [TAG_WIDTH-1:0]       s1_tag, s2_tag;
  om_color_t [NUM_LANES-1:0]  s1_src, s1_dst, s1_sf, s1_df;
  om_color_t [NUM_LANES-1:0]  s2_src, s2_dst, s2_sw, s2_dw;
  om_color_t [NUM_LANES-1:0]  f_src, f_dst, w_src, w_dst, blended;

`ifdef OM_BLEND_LOGICOP_EN
  logic [3:0] s1_lop, s2_lop;
`else
  logic [3:0] unused_logic_op;
  assign unused_logic_op = dcrs.logic_op;
`endif

  // Whole pipe moves together; the output stage only blocks when it holds a beat.
  assign advance   = ready_out || !v3;
  assign ready_in  = advance;
  assign valid_out = v3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      color_out <= '0;
      mask_out  <= '0;
      tag_out   <= '0;
    end else if (advance) begin
      v1        <= valid_in;
      v2        <= v1;
      v3        <= v2;
      color_out <= blended;
      mask_out  <= s2_mask;
      tag_out   <= s2_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_mode_rgb <= dcrs.blend_mode_rgb;
      s1_mode_a   <= dcrs.blend_mode_a;
      s1_mask     <= mask_in;
      s1_tag      <= tag_in;
      s1_src      <= src_color;
      s1_dst      <= dst_color;
      s1_sf       <= f_src;
      s1_df       <= f_dst;
      s2_mode_rgb <= s1_mode_rgb;
      s2_mode_a   <= s1_mode_a;
      s2_mask     <= s1_mask;
      s2_tag      <= s1_tag;
      s2_src      <= s1_src;
      s2_dst      <= s1_dst;
      s2_sw       <= w_src;
      s2_dw       <= w_dst;
`ifdef OM_BLEND_LOGICOP_EN
      s1_lop      <= dcrs.logic_op;
      s2_lop      <= s1_lop;
`endif
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    om_blend_lane u_lane (
      .src          (src_color[i]),
      .dst          (dst_color[i]),
      .func_src_rgb (dcrs.blend_src_rgb),
      .func_src_a   (dcrs.blend_src_a),
      .func_dst_rgb (dcrs.blend_dst_rgb),
      .func_dst_a   (dcrs.blend_dst_a),
      .blend_const  (dcrs.blend_const),
      .src_f        (f_src[i]),
      .dst_f        (f_dst[i]),
      .mul_src      (s1_src[i]),
      .mul_dst      (s1_dst[i]),
      .mul_src_f    (s1_sf[i]),
      .mul_dst_f    (s1_df[i]),
      .src_w        (w_src[i]),
      .dst_w        (w_dst[i]),
      .cmb_src      (s2_src[i]),
      .cmb_dst      (s2_dst[i]),
      .cmb_src_w    (s2_sw[i]),
      .cmb_dst_w    (s2_dw[i]),
      .mode_rgb     (s2_mode_rgb),
      .mode_a       (s2_mode_a),
`ifdef OM_BLEND_LOGICOP_EN
      .logic_op     (s2_lop),
`endif
      .mask         (s2_mask[i]),
      .color        (blended[i])
    );
  end

endmodule

// File: doc/om_blend_array.md
# om_blend_array

Multi-lane, pipelined output-merger blend engine: successor to the single-pixel blend unit, processing NUM_LANES pixels per beat under one set of blend DCRs. It sits between the depth/stencil stage and the colour write-back in the OM, with valid/ready flow control, per-lane write masks and a sideband tag. DCR state is captured per beat, so DCR changes never affect beats already in flight.

## Interface
- NUM_LANES, 4, pixels per beat (1..16)
- TAG_WIDTH, 8, opaque sideband carried input-to-output
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  input beat valid
- ready_in  out  1  input beat accepted when valid_in && ready_in
- dcrs  in  om_dcrs_t  blend_src/dst_rgb/a, blend_mode_rgb/a, blend_const, logic_op; sampled with the beat
- mask_in  in  NUM_LANES  per-lane enable
- src_color, dst_color  in  NUM_LANES x om_color_t  ARGB8888 per lane
- tag_in  in  TAG_WIDTH  sideband
- valid_out  out  1  output beat valid
- ready_out  in  1  downstream accepts
- color_out  out  NUM_LANES x om_color_t  blended result
- mask_out  out  NUM_LANES  mask_in delayed
- tag_out  out  TAG_WIDTH  tag_in delayed

## Operation
- S1, factor select: per lane, per channel, select an 8-bit factor from ZERO, ONE, SRC_RGB, ONE_MINUS_SRC_RGB, DST_RGB, ONE_MINUS_DST_RGB, SRC_A, ONE_MINUS_SRC_A, DST_A, ONE_MINUS_DST_A, CONST_RGB, ONE_MINUS_CONST_RGB, CONST_A, ONE_MINUS_CONST_A, ALPHA_SAT.
  - ALPHA_SAT = min(src_a, 255-dst_a) for RGB; 255 for alpha.
  - ONE_MINUS_x = 255-x.
- S2, multiply: p = c*f (16 bit); result = (p + 128 + ((p+128)>>8)) >> 8. This is exact rounded c*f/255, 8-bit, so 255*255 → 255.
- S3, combine: RGB uses blend_mode_rgb; A uses blend_mode_a.
  - ADD: min(s+d, 255), 9-bit intermediate.
  - SUB: max(s-d, 0).
  - REV_SUB: max(d-s, 0).
  - MIN/MAX: min or max of the unweighted src/dst colours.
  - LOGICOP: 16 standard ops on the raw src/dst bits, all 32 bits per lane.
- Masked-off lane: color_out = dst_color for that lane.
- Undefined func/mode encodings: treated as ZERO / ADD.

## Timing
- Fixed latency of 3 cycles from accepted beat to valid_out, with no bubbles at full throughput (1 beat/cycle).
- Global stall: advance = ready_out || !valid_s3. Define ready_in = advance.
- All stages, including DCRs, mask and tag, shift only on advance.
- Output holds stable while valid_out && !ready_out.
- Pipeline full and ready_out low: ready_in = 0 combinationally the same cycle.
- Accept and emit in the same cycle is allowed. Ordering is strictly FIFO.
- Reset: all stage valids are cleared asynchronously, so valid_out=0 and ready_in=1 from the next edge after release.
  - color_out, mask_out and tag_out reset to 0.
  - Datapath registers need no reset.
- Reset mid-operation: in-flight beats are discarded and never emitted.

## Configuration
- OM_BLEND_LOGICOP_EN defined: LOGICOP mode is supported as above.
- Undefined: LOGICOP decodes as ADD and the logic-op datapath and logic_op pipeline field are removed. Latency is unchanged.

## Structure
- om_pkg holds: om_color_t, om_dcrs_t, OM_BLEND_FUNC_* (4-bit), OM_BLEND_MODE_* (3-bit), OM_LOGIC_OP_* (4-bit).
- One sub-module, om_blend_lane: the combinational factor, multiply and combine logic for one lane, split at the two stage boundaries.
- Top level holds the pipeline registers, handshake and NUM_LANES instances.

## Test plan
- ONE/ZERO, ADD for rgb and a; src 0xb4ef4b7b, dst 0xc2c4267b → color_out 0xb4ef4b7b after exactly 3 cycles.
- Alpha blend (SRC_A / ONE_MINUS_SRC_A, ADD for both); src 0x80ff0000, dst 0xff0000ff → 0xbf80007f.
- OM_BLEND_LOGICOP_EN set, LOGICOP, AND_INVERTED; src 0x0ff0aa55, dst 0xffffffff → 0xf00f55aa. Without the macro, the same stimulus gives ADD saturation → 0xffffffff.
- SUB and REV_SUB, ONE/ONE; src 0x10101010, dst 0x20202020 → SUB 0x00000000, REV_SUB 0x10101010. mask_in=4'b0101 → lanes 1 and 3 output dst.
- Backpressure: send tags 1..5 back-to-back while ready_out is low for 6 cycles.
  - ready_in drops after 3 accepted beats.
  - Outputs then emerge as tags 1..5 in order, none lost or duplicated.
  - A dcrs change after acceptance does not alter in-flight results.
- Reset: assert reset with 2 beats in flight → valid_out 0 immediately. After release, no stale beat appears, and a fresh beat has latency 3.
